// File: rtl/frame_light_scheduler.sv
// frame_light_scheduler: frame-synchronous traffic light with pedestrian shortening and flashing-yellow mode.
module frame_light_scheduler #(
  parameter int FPS      = 60,
  parameter int RED_S    = 10,
  parameter int GREEN_S  = 8,
  parameter int YELLOW_S = 3,
  parameter int PED_S    = 2
) (
  input  logic       clk_HDMI,
  input  logic       rstn,
  input  logic       frame_start,
  input  logic       en,
  input  logic       ped_req,
  output logic [1:0] light_state,
  output logic [6:0] countdown,
  output logic       blink,
  output logic       ped_ack,
  output logic       update
);
  localparam logic [1:0] RED = 2'd0, GREEN = 2'd1, YELLOW = 2'd2, FLASH = 2'd3;
  localparam int CW = $clog2(FPS);
  localparam logic [CW-1:0] LAST = CW'(FPS - 1);
  localparam logic [CW-1:0] HALF = CW'(FPS / 2 - 1);
  logic [1:0] state_q, state_d;
  logic [6:0] cd_q, cd_d;
  logic [CW-1:0] fcnt_q, fcnt_d, hc_q, hc_d;
  logic blink_q, blink_d, pend_q, pend_d, ack_q, ack_d, upd_q, upd_d;
  logic tick;
  assign tick = fcnt_q == LAST;
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    fcnt_d  = fcnt_q;
    hc_d    = hc_q;
    blink_d = blink_q;
    pend_d  = pend_q | (ped_req & (state_q == GREEN || state_q == YELLOW));
    ack_d   = 1'b0;
    if (frame_start) begin
      if (!en) begin
        pend_d = 1'b0;
        if (state_q != FLASH) begin
          state_d = FLASH;
          cd_d    = '0;
          fcnt_d  = '0;
          hc_d    = '0;
          blink_d = 1'b0;
        end else begin
          hc_d    = hc_q == HALF ? '0 : hc_q + 1'b1;
          blink_d = blink_q ^ (hc_q == HALF);
        end
      end else if (state_q == FLASH) begin
        state_d = RED;
        cd_d    = 7'(RED_S);
        blink_d = 1'b0;
        fcnt_d  = '0;
        hc_d    = '0;
      end else begin
        fcnt_d = tick ? '0 : fcnt_q + 1'b1;
        if (tick && cd_q == 7'd1) begin
          state_d = state_q == RED ? GREEN : state_q == GREEN ? YELLOW : RED;
          cd_d    = state_q == RED ? 7'(GREEN_S) : state_q == GREEN ? 7'(YELLOW_S) : 7'(RED_S);
        end else if (tick)
          cd_d = (state_q == GREEN && pend_q && cd_q > 7'(PED_S)) ? 7'(PED_S) : cd_q - 1'b1;
      end
    end
    // A request arriving in the same cycle as RED entry is dropped, not carried over.
    if (state_d == RED && state_q != RED) begin
      ack_d  = pend_q;
      pend_d = 1'b0;
    end
    upd_d = (state_d != state_q) || (cd_d != cd_q);
  end
  always_ff @(posedge clk_HDMI) begin
    if (!rstn) begin
      state_q <= RED;
      cd_q    <= 7'(RED_S);
      fcnt_q  <= '0;
      hc_q    <= '0;
      blink_q <= 1'b0;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      fcnt_q  <= fcnt_d;
      hc_q    <= hc_d;
      blink_q <= blink_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      upd_q   <= upd_d;
    end
  end
  assign light_state = state_q;
  assign countdown   = cd_q;
  assign blink       = blink_q;
  assign ped_ack     = ack_q;
  assign update      = upd_q;
endmodule

// File: tb/tb_frame_light_scheduler.sv
// tb_frame_light_scheduler: random stimulus against a seconds/frames reference model of the light schedule.
module tb_frame_light_scheduler;
  localparam int FPS = 2, RED_S = 3, GREEN_S = 4, YELLOW_S = 2, PED_S = 2;
  logic clk_HDMI = 1'b0;
  logic rstn = 1'b0, frame_start = 1'b0, en = 1'b1, ped_req = 1'b0;
  logic [1:0] light_state;
  logic [6:0] countdown;
  logic blink, ped_ack, update;
  int vectors = 0, miscompares = 0;
  int st, sec, fr, hc, bl, pend, ack, upd;
  frame_light_scheduler #(.FPS(FPS), .RED_S(RED_S), .GREEN_S(GREEN_S), .YELLOW_S(YELLOW_S), .PED_S(PED_S)) dut (
    .clk_HDMI(clk_HDMI), .rstn(rstn), .frame_start(frame_start), .en(en), .ped_req(ped_req),
    .light_state(light_state), .countdown(countdown), .blink(blink), .ped_ack(ped_ack), .update(update)
  );
  always #5 clk_HDMI = ~clk_HDMI;
  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask
  function automatic int dur(input int p);
    return p == 0 ? RED_S : p == 1 ? GREEN_S : YELLOW_S;
  endfunction
  // Phases: 0 red, 1 green, 2 yellow, 3 flash; sec = whole seconds left, fr = frames into the second.
  task automatic model(input bit fs, input bit e, input bit pr, input bit rn);
    int old_st, old_sec, np;
    if (!rn) begin
      st = 0; sec = RED_S; fr = 0; hc = 0; bl = 0; pend = 0; ack = 0; upd = 0;
      return;
    end
    old_st = st; old_sec = sec; ack = 0;
    np = (pend || (pr && (st == 1 || st == 2))) ? 1 : 0;
    if (fs) begin
      if (!e) begin
        np = 0;
        if (st != 3) begin st = 3; sec = 0; fr = 0; hc = 0; bl = 0; end
        else if (hc == FPS / 2 - 1) begin bl = 1 - bl; hc = 0; end
        else hc++;
      end else if (st == 3) begin
        st = 0; sec = RED_S; bl = 0; fr = 0; hc = 0;
      end else begin
        fr++;
        if (fr == FPS) begin
          fr = 0;
          if (sec == 1) begin st = (st + 1) % 3; sec = dur(st); end
          else if (st == 1 && pend != 0 && sec > PED_S) sec = PED_S;
          else sec--;
        end
      end
    end
    if (st == 0 && old_st != 0) begin ack = pend; np = 0; end
    pend = np;
    upd = (st != old_st || sec != old_sec) ? 1 : 0;
  endtask
  task automatic step(input bit fs, input bit e, input bit pr, input bit rn);
    @(negedge clk_HDMI);
    frame_start = fs; en = e; ped_req = pr; rstn = rn;
    @(posedge clk_HDMI);
    model(fs, e, pr, rn);
    #1;
    chk("light_state", int'(light_state), st);
    chk("countdown", int'(countdown), sec);
    chk("blink", int'(blink), bl);
    chk("ped_ack", int'(ped_ack), ack);
    chk("update", int'(update), upd);
  endtask
  initial begin
    bit e = 1'b1;
    step(0, 1, 0, 0);
    step(1, 1, 1, 0);
    // Free run with sparse frames.
    for (int i = 0; i < 200; i++) step($urandom_range(0, 2) == 0, 1, 0, 1);
    // Pedestrian requests.
    for (int i = 0; i < 400; i++) step($urandom_range(0, 2) == 0, 1, $urandom_range(0, 15) == 0, 1);
    // Directed request at start of green, then free run to red entry.
    for (int i = 0; i < 60 && !(light_state == 2'd1 && countdown == 7'd4); i++) step(1, 1, 0, 1);
    step(0, 1, 1, 1);
    for (int i = 0; i < 20; i++) step(1, 1, 0, 1);
    // Flashing mode entered and left at random.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) e = ~e;
      step($urandom_range(0, 1) == 0, e, $urandom_range(0, 7) == 0, 1);
    end
    // Dense back-to-back frames with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) e = ~e;
      step($urandom_range(0, 3) != 0, e, $urandom_range(0, 5) == 0, $urandom_range(0, 99) != 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
